// File: rtl/parking_zoned_if.sv
// Gate-sensor / display bus of the zoned parking controller.
// Optional macro PARKING_WAITQ_EN adds the per-zone waiting-queue depth outputs.
interface parking_zoned_if #(
    parameter int unsigned CNT_W = 10
);
    logic             enable;
    logic             enable_cnt;
    logic             car_entered;
    logic             is_uni_car_entered;
    logic             car_exited;
    logic             is_uni_car_exited;

    logic [4:0]       h;
    logic [5:0]       m;
    logic [6:0]       d;
    logic [CNT_W-1:0] uni_parked_cars;
    logic [CNT_W-1:0] parked_cars;
    logic [CNT_W-1:0] uni_vacated_space;
    logic [CNT_W-1:0] vacated_space;
    logic             uni_is_vacated_space;
    logic             is_vacated_space;
    logic [CNT_W-1:0] uni_cap_now;
    logic [CNT_W-1:0] gen_cap_now;
    logic             no_car_error;
    logic             entry_reject;
    logic             uni_capacity_error;
    logic             capacity_error;
`ifdef PARKING_WAITQ_EN
    logic [3:0]       uni_waiting;
    logic [3:0]       waiting;
`endif

    // Sensor side: drives strobes, observes status.
    modport master (
        output enable, enable_cnt, car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
        input  h, m, d, uni_parked_cars, parked_cars, uni_vacated_space, vacated_space,
               uni_is_vacated_space, is_vacated_space, uni_cap_now, gen_cap_now,
               no_car_error, entry_reject, uni_capacity_error, capacity_error
`ifdef PARKING_WAITQ_EN
               , uni_waiting, waiting
`endif
    );

    // Controller side.
    modport slave (
        input  enable, enable_cnt, car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
        output h, m, d, uni_parked_cars, parked_cars, uni_vacated_space, vacated_space,
               uni_is_vacated_space, is_vacated_space, uni_cap_now, gen_cap_now,
               no_car_error, entry_reject, uni_capacity_error, capacity_error
`ifdef PARKING_WAITQ_EN
               , uni_waiting, waiting
`endif
    );
endinterface

// File: rtl/parking_zoned.sv
// Two-zone (university / general) parking controller with time-of-day clock
// and scheduled university capacity. Every output is a flop; capacity and
// vacancy registers are loaded from next-state values so they move in the
// same cycle as the hour and the counts.
// Optional macro PARKING_WAITQ_EN: rejected entries queue (depth 15 per zone).
module parking_zoned #(
    parameter int unsigned CNT_W         = 10,
    parameter int unsigned TOTAL_CAP     = 700,
    parameter int unsigned UNI_CAP_MAX   = 500,
    parameter int unsigned UNI_CAP_STEP  = 50,
    parameter int unsigned RELEASE_STEPS = 6,
    parameter int unsigned OPEN_HOUR     = 8,
    parameter int unsigned RELEASE_HOUR  = 13,
    parameter int unsigned MIN_TICKS     = 1,
    parameter int unsigned START_HOUR    = 0
) (
    input  logic           clk,
    input  logic           reset_cnt,
    parking_zoned_if.slave bus
);
    localparam int unsigned TICK_W      = (MIN_TICKS > 1) ? $clog2(MIN_TICKS) : 1;
    localparam int unsigned UNI_CAP_MIN = UNI_CAP_MAX - RELEASE_STEPS * UNI_CAP_STEP;

    // Elaboration-time sanity checks on the parameter set.
    if (CNT_W < 32 && TOTAL_CAP > (2 ** CNT_W) - 1) begin : g_cnt_w_check
        $error("CNT_W too narrow for TOTAL_CAP");
    end
    if (RELEASE_STEPS * UNI_CAP_STEP > UNI_CAP_MAX || UNI_CAP_MAX > TOTAL_CAP) begin : g_cap_check
        $error("inconsistent capacity parameters");
    end
    if (MIN_TICKS < 1 || START_HOUR > 23) begin : g_time_check
        $error("MIN_TICKS must be >= 1 and START_HOUR <= 23");
    end

    // Scheduled university capacity for a given hour.
    function automatic logic [CNT_W-1:0] sched_cap(input logic [4:0] hr);
        int unsigned hv;
        int unsigned cap;
        hv = 32'(hr);
        if (hv < OPEN_HOUR)
            cap = UNI_CAP_MIN;
        else if (hv < RELEASE_HOUR)
            cap = UNI_CAP_MAX;
        else if (hv < RELEASE_HOUR + RELEASE_STEPS)
            cap = UNI_CAP_MAX - (hv - RELEASE_HOUR + 1) * UNI_CAP_STEP;
        else
            cap = UNI_CAP_MIN;
        return CNT_W'(cap);
    endfunction

    logic [TICK_W-1:0] tick_q, tick_n;
    logic [5:0]        m_q, m_n;
    logic [4:0]        h_q, h_n;
    logic [6:0]        d_q, d_n;
    logic [CNT_W-1:0]  uni_q, uni_n, gen_q, gen_n;
    logic [CNT_W-1:0]  ucap_q, ucap_n, gcap_q, gcap_n;
    logic [CNT_W-1:0]  uvac_q, uvac_n, gvac_q, gvac_n;
    logic              uerr_q, uerr_n, gerr_q, gerr_n;
    logic              nce_q, nce_n, rej_q, rej_n;
    logic [CNT_W-1:0]  rst_ucap, rst_gcap;

    logic u_exit_req, g_exit_req, u_exit_ok, g_exit_ok;
    logic u_entry_req, g_entry_req, u_entry_ok, g_entry_ok;
    logic u_rej, g_rej, u_inc, g_inc;

    assign rst_ucap = sched_cap(5'(START_HOUR));
    assign rst_gcap = CNT_W'(TOTAL_CAP) - rst_ucap;

`ifdef PARKING_WAITQ_EN
    logic [3:0] uwait_q, uwait_n, gwait_q, gwait_n;
    logic       u_admit, g_admit;
`endif

    // Next-state: time of day, zone events, then derived capacity/vacancy.
    always_comb begin
        tick_n = tick_q;
        m_n    = m_q;
        h_n    = h_q;
        d_n    = d_q;
        if (bus.enable_cnt) begin
            if (tick_q == TICK_W'(MIN_TICKS - 1)) begin
                tick_n = '0;
                if (m_q == 6'd59) begin
                    m_n = '0;
                    if (h_q == 5'd23) begin
                        h_n = '0;
                        d_n = d_q + 7'd1;
                    end else begin
                        h_n = h_q + 5'd1;
                    end
                end else begin
                    m_n = m_q + 6'd1;
                end
            end else begin
                tick_n = tick_q + TICK_W'(1);
            end
        end

        u_exit_req  = bus.enable && bus.car_exited && bus.is_uni_car_exited;
        g_exit_req  = bus.enable && bus.car_exited && !bus.is_uni_car_exited;
        u_entry_req = bus.enable && bus.car_entered && bus.is_uni_car_entered;
        g_entry_req = bus.enable && bus.car_entered && !bus.is_uni_car_entered;

        u_exit_ok  = u_exit_req && (uni_q != '0);
        g_exit_ok  = g_exit_req && (gen_q != '0);
        u_entry_ok = u_entry_req && ((uni_q < ucap_q) || u_exit_ok);
        g_entry_ok = g_entry_req && ((gen_q < gcap_q) || g_exit_ok);
        u_rej      = u_entry_req && !u_entry_ok;
        g_rej      = g_entry_req && !g_entry_ok;

        nce_n = (u_exit_req && !u_exit_ok) || (g_exit_req && !g_exit_ok);

`ifdef PARKING_WAITQ_EN
        // A queued car moves in when the zone had room and no direct entry used it.
        u_admit = (uwait_q != 4'd0) && (uni_q < ucap_q) && !u_entry_ok;
        g_admit = (gwait_q != 4'd0) && (gen_q < gcap_q) && !g_entry_ok;
        uwait_n = uwait_q;
        gwait_n = gwait_q;
        if (u_rej && uwait_q != 4'd15) uwait_n = uwait_q + 4'd1;
        if (u_admit)                   uwait_n = uwait_q - 4'd1;
        if (g_rej && gwait_q != 4'd15) gwait_n = gwait_q + 4'd1;
        if (g_admit)                   gwait_n = gwait_q - 4'd1;
        rej_n = (u_rej && uwait_q == 4'd15) || (g_rej && gwait_q == 4'd15);
        u_inc = u_entry_ok || u_admit;
        g_inc = g_entry_ok || g_admit;
`else
        rej_n = u_rej || g_rej;
        u_inc = u_entry_ok;
        g_inc = g_entry_ok;
`endif

        uni_n = uni_q + CNT_W'(u_inc) - CNT_W'(u_exit_ok);
        gen_n = gen_q + CNT_W'(g_inc) - CNT_W'(g_exit_ok);

        ucap_n = sched_cap(h_n);
        gcap_n = CNT_W'(TOTAL_CAP) - ucap_n;
        uvac_n = (uni_n < ucap_n) ? (ucap_n - uni_n) : '0;
        gvac_n = (gen_n < gcap_n) ? (gcap_n - gen_n) : '0;
        uerr_n = uni_n > ucap_n;
        gerr_n = gen_n > gcap_n;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset_cnt) begin
            tick_q <= '0;
            m_q    <= '0;
            h_q    <= 5'(START_HOUR);
            d_q    <= '0;
            uni_q  <= '0;
            gen_q  <= '0;
            ucap_q <= rst_ucap;
            gcap_q <= rst_gcap;
            uvac_q <= rst_ucap;
            gvac_q <= rst_gcap;
            uerr_q <= 1'b0;
            gerr_q <= 1'b0;
            nce_q  <= 1'b0;
            rej_q  <= 1'b0;
`ifdef PARKING_WAITQ_EN
            uwait_q <= '0;
            gwait_q <= '0;
`endif
        end else begin
            tick_q <= tick_n;
            m_q    <= m_n;
            h_q    <= h_n;
            d_q    <= d_n;
            uni_q  <= uni_n;
            gen_q  <= gen_n;
            ucap_q <= ucap_n;
            gcap_q <= gcap_n;
            uvac_q <= uvac_n;
            gvac_q <= gvac_n;
            uerr_q <= uerr_n;
            gerr_q <= gerr_n;
            nce_q  <= nce_n;
            rej_q  <= rej_n;
`ifdef PARKING_WAITQ_EN
            uwait_q <= uwait_n;
            gwait_q <= gwait_n;
`endif
        end
    end

    assign bus.h                    = h_q;
    assign bus.m                    = m_q;
    assign bus.d                    = d_q;
    assign bus.uni_parked_cars      = uni_q;
    assign bus.parked_cars          = gen_q;
    assign bus.uni_vacated_space    = uvac_q;
    assign bus.vacated_space        = gvac_q;
    assign bus.uni_is_vacated_space = (uvac_q != '0);
    assign bus.is_vacated_space     = (gvac_q != '0);
    assign bus.uni_cap_now          = ucap_q;
    assign bus.gen_cap_now          = gcap_q;
    assign bus.no_car_error         = nce_q;
    assign bus.entry_reject         = rej_q;
    assign bus.uni_capacity_error   = uerr_q;
    assign bus.capacity_error       = gerr_q;
`ifdef PARKING_WAITQ_EN
    assign bus.uni_waiting          = uwait_q;
    assign bus.waiting              = gwait_q;
`endif
endmodule

// File: tb/tb_parking_zoned.sv
// Bench for parking_zoned: directed scenarios plus a randomized run checked
// against a minute-count / occupancy reference model.
module tb_parking_zoned;
    localparam int TOTAL = 700;
    localparam int UMAX  = 500;
    localparam int STEP  = 50;
    localparam int STEPS = 6;
    localparam int OPEN  = 8;
    localparam int REL   = 13;
    localparam int UMIN  = UMAX - STEPS * STEP;

    logic clk = 1'b0;
    logic reset_cnt;
    parking_zoned_if #(.CNT_W(10)) bus ();

    parking_zoned dut (.clk(clk), .reset_cnt(reset_cnt), .bus(bus));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: absolute minutes since reset plus zone state.
    int mins, ticks, m_ucnt, m_gcnt, m_uwait, m_gwait;
    bit m_nce, m_rej;

    function automatic int cap_uni(input int hr);
        if (hr < OPEN) return UMIN;
        if (hr < REL) return UMAX;
        if (hr < REL + STEPS) return UMAX - (hr - REL + 1) * STEP;
        return UMIN;
    endfunction

    function automatic int cur_hour();
        return (mins / 60) % 24;
    endfunction

    // Drive one cycle of stimulus and advance the model by the same edge.
    task automatic step(input bit en, input bit en_cnt, input bit ce, input bit ceu,
                        input bit cx, input bit cxu);
        int ucap, gcap;
        bit uxr, gxr, uxo, gxo, uer, ger, ueo, geo, ua, ga;
        bus.enable = en;  bus.enable_cnt = en_cnt;
        bus.car_entered = ce; bus.is_uni_car_entered = ceu;
        bus.car_exited = cx;  bus.is_uni_car_exited = cxu;
        ucap = cap_uni(cur_hour());
        gcap = TOTAL - ucap;
        uxr = en && cx && cxu;   gxr = en && cx && !cxu;
        uer = en && ce && ceu;   ger = en && ce && !ceu;
        uxo = uxr && (m_ucnt > 0);
        gxo = gxr && (m_gcnt > 0);
        ueo = uer && (m_ucnt < ucap || uxo);
        geo = ger && (m_gcnt < gcap || gxo);
        m_nce = (uxr && !uxo) || (gxr && !gxo);
        m_rej = 1'b0;
        ua = 1'b0; ga = 1'b0;
`ifdef PARKING_WAITQ_EN
        ua = (m_uwait > 0) && (m_ucnt < ucap) && !ueo;
        ga = (m_gwait > 0) && (m_gcnt < gcap) && !geo;
        if (uer && !ueo) begin if (m_uwait < 15) m_uwait++; else m_rej = 1'b1; end
        if (ger && !geo) begin if (m_gwait < 15) m_gwait++; else m_rej = 1'b1; end
        if (ua) m_uwait--;
        if (ga) m_gwait--;
`else
        if ((uer && !ueo) || (ger && !geo)) m_rej = 1'b1;
`endif
        m_ucnt = m_ucnt + int'(ueo) + int'(ua) - int'(uxo);
        m_gcnt = m_gcnt + int'(geo) + int'(ga) - int'(gxo);
        if (en_cnt) begin
            ticks++;
            if (ticks == 1) begin ticks = 0; mins++; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_cnt = 1'b1;
        bus.enable = 1'b1; bus.enable_cnt = 1'b1;
        bus.car_entered = 1'b1; bus.is_uni_car_entered = 1'b1;
        bus.car_exited = 1'b0; bus.is_uni_car_exited = 1'b0;
        @(posedge clk);
        #1;
        reset_cnt = 1'b0;
        mins = 0; ticks = 0; m_ucnt = 0; m_gcnt = 0; m_uwait = 0; m_gwait = 0;
        m_nce = 1'b0; m_rej = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({bus.h, bus.m, bus.d} !== 18'd0)
            $display("FAIL reset_time: got h=%0d m=%0d d=%0d, want 0/0/0", bus.h, bus.m, bus.d);
        else n_pass++;
        n_checks++;
        if ({bus.uni_parked_cars, bus.parked_cars} !== 20'd0)
            $display("FAIL reset_counts: got %0d/%0d, want 0/0", bus.uni_parked_cars, bus.parked_cars);
        else n_pass++;
        n_checks++;
        if ({bus.no_car_error, bus.entry_reject, bus.uni_capacity_error, bus.capacity_error} !== 4'b0)
            $display("FAIL reset_flags: got %b, want 0000",
                     {bus.no_car_error, bus.entry_reject, bus.uni_capacity_error, bus.capacity_error});
        else n_pass++;
        n_checks++;
        if (bus.uni_cap_now !== 10'(UMIN) || bus.gen_cap_now !== 10'(TOTAL - UMIN))
            $display("FAIL reset_caps: got %0d/%0d, want %0d/%0d",
                     bus.uni_cap_now, bus.gen_cap_now, UMIN, TOTAL - UMIN);
        else n_pass++;
    endtask

    task automatic test_no_car();
        step(1, 0, 0, 0, 1, 0);
        n_checks++;
        if (bus.no_car_error !== 1'b1 || bus.parked_cars !== 10'd0)
            $display("FAIL no_car_pulse: got err=%b cnt=%0d, want 1/0", bus.no_car_error, bus.parked_cars);
        else n_pass++;
        step(1, 0, 0, 0, 0, 0);
        n_checks++;
        if (bus.no_car_error !== 1'b0)
            $display("FAIL no_car_clear: got %b, want 0", bus.no_car_error);
        else n_pass++;
    endtask

    task automatic test_time();
        for (int i = 0; i < 480; i++) step(0, 1, 0, 0, 0, 0);
        n_checks++;
        if (bus.h !== 5'd8 || bus.m !== 6'd0 || bus.d !== 7'd0)
            $display("FAIL time_480: got h=%0d m=%0d d=%0d, want 8/0/0", bus.h, bus.m, bus.d);
        else n_pass++;
        n_checks++;
        if (bus.uni_cap_now !== 10'd500 || bus.gen_cap_now !== 10'd200)
            $display("FAIL cap_open: got %0d/%0d, want 500/200", bus.uni_cap_now, bus.gen_cap_now);
        else n_pass++;
    endtask

    task automatic test_gen_full();
        for (int i = 0; i < 200; i++) step(1, 0, 1, 0, 0, 0);
        n_checks++;
        if (bus.parked_cars !== 10'd200 || bus.is_vacated_space !== 1'b0 || bus.vacated_space !== 10'd0)
            $display("FAIL gen_fill: got cnt=%0d vac=%0d flag=%b, want 200/0/0",
                     bus.parked_cars, bus.vacated_space, bus.is_vacated_space);
        else n_pass++;
        step(1, 0, 1, 0, 1, 0);
        n_checks++;
        if (bus.parked_cars !== 10'd200 || bus.entry_reject !== 1'b0 || bus.no_car_error !== 1'b0)
            $display("FAIL gen_swap: got cnt=%0d rej=%b err=%b, want 200/0/0",
                     bus.parked_cars, bus.entry_reject, bus.no_car_error);
        else n_pass++;
    endtask

    task automatic test_uni_fill();
        for (int i = 0; i < 60; i++) step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 500; i++) step(1, 0, 1, 1, 0, 0);
        n_checks++;
        if (bus.uni_parked_cars !== 10'd500 || bus.uni_is_vacated_space !== 1'b0 || bus.h !== 5'd9)
            $display("FAIL uni_fill: got cnt=%0d flag=%b h=%0d, want 500/0/9",
                     bus.uni_parked_cars, bus.uni_is_vacated_space, bus.h);
        else n_pass++;
        step(1, 0, 1, 1, 0, 0);
`ifdef PARKING_WAITQ_EN
        n_checks++;
        if (bus.entry_reject !== 1'b0 || bus.uni_waiting !== 4'd1 || bus.uni_parked_cars !== 10'd500)
            $display("FAIL uni_queue1: got rej=%b wait=%0d cnt=%0d, want 0/1/500",
                     bus.entry_reject, bus.uni_waiting, bus.uni_parked_cars);
        else n_pass++;
        step(1, 0, 1, 1, 0, 0);
        step(1, 0, 1, 1, 0, 0);
        n_checks++;
        if (bus.uni_waiting !== 4'd3)
            $display("FAIL uni_queue3: got %0d, want 3", bus.uni_waiting);
        else n_pass++;
        step(1, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0, 0);
        n_checks++;
        if (bus.uni_parked_cars !== 10'd500 || bus.uni_waiting !== 4'd2)
            $display("FAIL uni_admit: got cnt=%0d wait=%0d, want 500/2", bus.uni_parked_cars, bus.uni_waiting);
        else n_pass++;
`else
        n_checks++;
        if (bus.entry_reject !== 1'b1 || bus.uni_parked_cars !== 10'd500)
            $display("FAIL uni_reject: got rej=%b cnt=%0d, want 1/500", bus.entry_reject, bus.uni_parked_cars);
        else n_pass++;
        step(1, 0, 0, 0, 0, 0);
        n_checks++;
        if (bus.entry_reject !== 1'b0)
            $display("FAIL reject_clear: got %b, want 0", bus.entry_reject);
        else n_pass++;
`endif
    endtask

    task automatic test_shrink();
        for (int i = 0; i < 240; i++) step(0, 1, 0, 0, 0, 0);
        n_checks++;
        if (bus.h !== 5'd13 || bus.uni_cap_now !== 10'd450 || bus.uni_capacity_error !== 1'b1 ||
            bus.uni_vacated_space !== 10'd0 || bus.uni_is_vacated_space !== 1'b0)
            $display("FAIL shrink_13: got h=%0d cap=%0d err=%b vac=%0d flag=%b, want 13/450/1/0/0",
                     bus.h, bus.uni_cap_now, bus.uni_capacity_error, bus.uni_vacated_space,
                     bus.uni_is_vacated_space);
        else n_pass++;
        for (int i = 1; i <= 51; i++) begin
            step(1, 0, 0, 0, 1, 1);
            n_checks++;
            if (bus.uni_capacity_error !== (500 - i > 450) || bus.uni_parked_cars !== 10'(500 - i))
                $display("FAIL shrink_exit%0d: got err=%b cnt=%0d, want %b/%0d", i,
                         bus.uni_capacity_error, bus.uni_parked_cars, (500 - i > 450), 500 - i);
            else n_pass++;
        end
        n_checks++;
        if (bus.uni_vacated_space !== 10'd1 || bus.uni_is_vacated_space !== 1'b1)
            $display("FAIL shrink_vac: got %0d/%b, want 1/1", bus.uni_vacated_space, bus.uni_is_vacated_space);
        else n_pass++;
    endtask

    task automatic test_random();
        int eu, eg, euv, egv, ph, errs;
        bit en, ec, ce, cx;
        do_reset();
        errs = 0;
        for (int i = 0; i < 3000; i++) begin
            ph = i / 1000;
            en = ($urandom % 8) != 0;
            ec = ($urandom % 2) != 0;
            ce = (ph == 1) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
            cx = (ph == 1) ? (($urandom % 4) != 0) : (($urandom % 3) == 0);
            step(en, ec, ce, 1'($urandom % 2), cx, 1'($urandom % 2));
            eu  = cap_uni(cur_hour());
            eg  = TOTAL - eu;
            euv = (m_ucnt < eu) ? eu - m_ucnt : 0;
            egv = (m_gcnt < eg) ? eg - m_gcnt : 0;
            n_checks++;
            if ({bus.h, bus.m, bus.d, bus.uni_cap_now, bus.gen_cap_now} !==
                {5'(cur_hour()), 6'(mins % 60), 7'((mins / 1440) % 128), 10'(eu), 10'(eg)}) begin
                if (errs < 10) $display("FAIL rand_time[%0d]: got h=%0d m=%0d d=%0d cap=%0d/%0d, want %0d/%0d/%0d %0d/%0d",
                    i, bus.h, bus.m, bus.d, bus.uni_cap_now, bus.gen_cap_now,
                    cur_hour(), mins % 60, (mins / 1440) % 128, eu, eg);
                errs++;
            end else n_pass++;
            n_checks++;
            if ({bus.uni_parked_cars, bus.parked_cars, bus.uni_vacated_space, bus.vacated_space,
                 bus.uni_is_vacated_space, bus.is_vacated_space, bus.no_car_error, bus.entry_reject,
                 bus.uni_capacity_error, bus.capacity_error} !==
                {10'(m_ucnt), 10'(m_gcnt), 10'(euv), 10'(egv), euv != 0, egv != 0, m_nce, m_rej,
                 m_ucnt > eu, m_gcnt > eg}) begin
                if (errs < 10) $display("FAIL rand_zone[%0d]: got cnt=%0d/%0d vac=%0d/%0d nce=%b rej=%b err=%b%b, want %0d/%0d %0d/%0d %b %b %b%b",
                    i, bus.uni_parked_cars, bus.parked_cars, bus.uni_vacated_space, bus.vacated_space,
                    bus.no_car_error, bus.entry_reject, bus.uni_capacity_error, bus.capacity_error,
                    m_ucnt, m_gcnt, euv, egv, m_nce, m_rej, m_ucnt > eu, m_gcnt > eg);
                errs++;
            end else n_pass++;
`ifdef PARKING_WAITQ_EN
            n_checks++;
            if ({bus.uni_waiting, bus.waiting} !== {4'(m_uwait), 4'(m_gwait)}) begin
                if (errs < 10) $display("FAIL rand_wait[%0d]: got %0d/%0d, want %0d/%0d",
                    i, bus.uni_waiting, bus.waiting, m_uwait, m_gwait);
                errs++;
            end else n_pass++;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_no_car();
        test_time();
        test_gen_full();
        test_uni_fill();
        test_shrink();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
